mips_dmem: RTL and testbench

Responder for the MIPS I core data bus (DA/we/DO/re/DI); it is the memory-side end of the core's MEM stage.
- Address bit 31 clear: byte-writable internal RAM with combinational read, so load data reaches the core in the same cycle as DA.
- Address bit 31 set: small I/O page holding a transmit FIFO (drained through a valid/ready port), a FIFO status register and a free-running cycle counter.
- The core cannot stall, so every access completes in zero wait states.

---
 rtl/mips_dmem_pkg.sv | 35 +++
 rtl/mips_txfifo.sv | 103 ++++++++++
 rtl/mips_dmem.sv | 129 ++++++++++++
 tb/tb_mips_dmem.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_dmem_pkg.sv
// Shared definitions for the MIPS data-bus responder: I/O decode, register
// offsets and STATUS register layout.
package mips_dmem_pkg;

    localparam int IO_SEL_BIT = 31;

    typedef enum logic [1:0] {
        OFF_TXDATA   = 2'd0,
        OFF_STATUS   = 2'd1,
        OFF_CYCLE    = 2'd2,
        OFF_UNMAPPED = 2'd3
    } io_off_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_MSB = 15;

    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] s;
        s                             = 32'd0;
        s[ST_EMPTY]                   = empty;
        s[ST_FULL]                    = full;
        s[ST_OVF]                     = ovf;
        s[ST_COUNT_MSB:ST_COUNT_LSB]  = count;
        return s;
    endfunction

endpackage

// File: rtl/mips_txfifo.sv
// Transmit FIFO with a registered head byte; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module mips_txfifo
    import mips_dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic [7:0] count,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    dout_q, dout_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          pop_ok_s;
    logic          push_ok_s;

    // Next-state pointers, occupancy and head byte.
    always_comb begin
        pop_ok_s  = pop & ~empty_q;
        push_ok_s = push & (~full_q | pop_ok_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The new head is the byte being written when it lands at the read slot.
        if (count_d == '0) begin
            dout_d = dout_q;
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= 8'd0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (!reset && push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign count = 8'(count_q);
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/mips_dmem.sv
// Memory-side responder for the MIPS core data bus: byte-writable RAM below
// bit 31, and an I/O page with transmit FIFO, STATUS and CYCLE above it.
module mips_dmem
    import mips_dmem_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DA,
    input  logic [3:0]  we,
    input  logic [31:0] DO,
    input  logic        re,
    output logic [31:0] DI,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic [31:0]   ram_q [2**AW];
    logic          io_sel_s;
    io_off_e       io_off_s;
    logic [AW-1:0] ram_idx_s;
    logic          unused_da_bits;

    logic          txdata_wr_s;
    logic          status_clr_s;
    logic          cycle_ld_s;
    logic          push_rej_s;

    logic          fifo_pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [7:0]    fifo_count_s;
    logic [31:0]   status_s;

    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;

    assign io_sel_s       = DA[IO_SEL_BIT];
    assign io_off_s       = io_off_e'(DA[3:2]);
    assign ram_idx_s      = DA[AW+1:2];
    assign unused_da_bits = ^{DA[1:0], DA[30:AW+2]};

    assign tx_valid   = ~fifo_empty_s;
    assign fifo_pop_s = tx_valid & tx_ready;

    mips_txfifo #(
        .DEPTH (DEPTH)
    ) u_txfifo (
        .clock (clock),
        .reset (reset),
        .push  (txdata_wr_s),
        .din   (DO[7:0]),
        .pop   (fifo_pop_s),
        .dout  (tx_data),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // I/O register decode and next-state for overflow and the cycle counter.
    always_comb begin
        txdata_wr_s  = io_sel_s & (io_off_s == OFF_TXDATA) & we[0];
        status_clr_s = io_sel_s & (io_off_s == OFF_STATUS) & we[0] & DO[ST_OVF];
        cycle_ld_s   = io_sel_s & (io_off_s == OFF_CYCLE) & (we == 4'b1111);
        push_rej_s   = txdata_wr_s & fifo_full_s & ~fifo_pop_s;
        ovf_d        = ovf_q;
        cycle_d      = cycle_q + 32'd1;

        // A rejected push outranks a simultaneous clear.
        if (push_rej_s) begin
            ovf_d = 1'b1;
        end else if (status_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // A load shows up as DO on the load edge, so DO+1 is visible next cycle.
        if (cycle_ld_s) begin
            cycle_d = DO + 32'd1;
        end else begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    // Overflow flag and free-running cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            cycle_q <= 32'd0;
        end else begin
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // Byte-lane RAM writes; contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && !io_sel_s) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    ram_q[ram_idx_s][8*i +: 8] <= DO[8*i +: 8];
                end
            end
        end
    end

    assign status_s = pack_status(fifo_empty_s, fifo_full_s, ovf_q, fifo_count_s);

    // Zero-wait-state load data mux; reads see pre-edge state.
    always_comb begin
        DI = 32'd0;
        if (!re) begin
            DI = 32'd0;
        end else if (!io_sel_s) begin
            DI = ram_q[ram_idx_s];
        end else begin
            case (io_off_s)
                OFF_STATUS: DI = status_s;
                OFF_CYCLE:  DI = cycle_q;
                default:    DI = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem.sv
// Randomised bench for mips_dmem against a queue/array reference model,
// preceded by directed scenarios with literal expectations.
module tb_mips_dmem;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] DA;
    logic [3:0]  we;
    logic [31:0] DO;
    logic        re;
    logic [31:0] DI;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clock = ~clock;

    mips_dmem #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .DA       (DA),
        .we       (we),
        .DO       (DO),
        .re       (re),
        .DI       (DI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram_m [2**AW];
    logic [7:0]  q_m [$];
    logic        ovf_m;
    logic [31:0] cyc_m;

    logic [31:0] last_di;
    logic        last_txv;
    logic [7:0]  last_txd;
    logic [7:0]  exp_b [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic r);
        int n;
        n = q_m.size();
        if (!r) return 32'd0;
        if (!a[31]) return ram_m[a[AW+1:2]];
        case (a[3:2])
            2'd1:    return {16'd0, 8'(n), 5'd0, ovf_m, (n == DEPTH), (n == 0)};
            2'd2:    return cyc_m;
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive, check outputs against the model, then advance the model.
    task automatic drive(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                         input logic r, input logic rdy, input logic rst);
        bit pop, push, rej, clr;
        @(negedge clock);
        DA = a; we = w; DO = d; re = r; tx_ready = rdy; reset = rst;
        #1;
        last_di  = DI;
        last_txv = tx_valid;
        last_txd = tx_data;
        check_eq("DI", DI, model_read(a, r));
        check_eq("tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(q_m[0]));

        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = 32'd0;
        end else begin
            pop  = (q_m.size() != 0) && rdy;
            push = a[31] && (a[3:2] == 2'd0) && w[0];
            rej  = push && (q_m.size() == DEPTH) && !pop;
            clr  = a[31] && (a[3:2] == 2'd1) && w[0] && d[2];
            if (pop) void'(q_m.pop_front());
            if (push && !rej) q_m.push_back(d[7:0]);
            if (rej) ovf_m = 1'b1;
            else if (clr) ovf_m = 1'b0;
            cyc_m = (a[31] && (a[3:2] == 2'd2) && (w == 4'hF)) ? d + 32'd1 : cyc_m + 32'd1;
            if (!a[31]) begin
                for (int i = 0; i < 4; i++) begin
                    if (w[i]) ram_m[a[AW+1:2]][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        drive(32'h8000_0000, 4'h1, {24'd0, b}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_status(input logic rdy);
        drive(32'h8000_0004, 4'h0, 32'd0, 1'b1, rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;

        reset = 1'b1; DA = 32'd0; we = 4'd0; DO = 32'd0; re = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clock);
        q_m.delete();
        ovf_m = 1'b0;
        cyc_m = 32'd0;

        read_status(1'b0);
        check_eq("reset_status", last_di, 32'h0000_0001);
        check_eq("reset_txv", 32'(last_txv), 32'd0);

        for (int i = 0; i < 2**AW; i++) begin
            drive(32'(i) << 2, 4'hF, $urandom, 1'b0, 1'b0, 1'b0);
        end

        drive(32'h40, 4'hF, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0);
        drive(32'h40, 4'b0010, 32'h0000_1100, 1'b0, 1'b0, 1'b0);
        drive(32'h40, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("ram_lane", last_di, 32'hAABB_11DD);
        drive(32'h40 + (32'd1 << (AW + 2)), 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("ram_alias", last_di, 32'hAABB_11DD);
        drive(32'h40, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        check_eq("ram_rdw_old", last_di, 32'hAABB_11DD);
        drive(32'h40, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("ram_rdw_new", last_di, 32'h1234_5678);

        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
        read_status(1'b0);
        check_eq("fifo_full_status", last_di, 32'h0000_0402);
        push_byte(8'h55);
        read_status(1'b0);
        check_eq("fifo_ovf_status", last_di, 32'h0000_0406);
        for (int i = 0; i < 4; i++) begin
            drive(32'd0, 4'h0, 32'd0, 1'b0, 1'b1, 1'b0);
            check_eq("drain_byte", 32'(last_txd), 32'(exp_b[i]));
        end
        read_status(1'b1);
        check_eq("drain_txv", 32'(last_txv), 32'd0);
        check_eq("drain_status", last_di, 32'h0000_0005);

        drive(32'h8000_0004, 4'h1, 32'h4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        drive(32'h8000_0000, 4'h1, 32'h99, 1'b0, 1'b1, 1'b0);
        read_status(1'b0);
        check_eq("full_pop_status", last_di, 32'h0000_0402);
        for (int i = 0; i < 4; i++) drive(32'd0, 4'h0, 32'd0, 1'b0, 1'b1, 1'b0);
        check_eq("full_pop_last", 32'(last_txd), 32'h99);

        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        read_status(1'b0);
        check_eq("ovf_set", last_di, 32'h0000_0406);
        drive(32'h8000_0004, 4'h1, 32'h4, 1'b0, 1'b0, 1'b0);
        read_status(1'b0);
        check_eq("ovf_clear", last_di, 32'h0000_0402);
        for (int i = 0; i < 4; i++) drive(32'd0, 4'h0, 32'd0, 1'b0, 1'b1, 1'b0);

        drive(32'h8000_0008, 4'hF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        drive(32'h8000_0008, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("cycle_load", last_di, 32'hFFFF_FFFF);
        drive(32'h8000_0008, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("cycle_wrap", last_di, 32'h0000_0000);
        drive(32'h8000_0008, 4'b0011, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("cycle_partial_a", last_di, 32'h0000_0001);
        drive(32'h8000_0008, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("cycle_partial_b", last_di, 32'h0000_0002);

        for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
        drive(32'd0, 4'h0, 32'd0, 1'b0, 1'b1, 1'b1);
        drive(32'h8000_0008, 4'h0, 32'd0, 1'b1, 1'b1, 1'b0);
        check_eq("rst_cycle", last_di, 32'h0000_0000);
        check_eq("rst_txv", 32'(last_txv), 32'd0);
        read_status(1'b0);
        check_eq("rst_status_mid", last_di, 32'h0000_0001);
        drive(32'h40, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("rst_ram_kept", last_di, 32'h1234_5678);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 4) a = {1'b1, 27'($urandom), 2'($urandom), 2'b00};
            else                          a = {1'b0, 29'($urandom), 2'b00};
            case ($urandom_range(0, 3))
                0:       w = 4'h0;
                1:       w = 4'hF;
                default: w = 4'($urandom);
            endcase
            drive(a, w, $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
